memory_controller: RTL and testbench

- Shared backing-store stage directly downstream of two cache instances.
- Consumes each cache's 25-bit memory_request / memory_request_ready pair.
- Arbitrates round-robin, performs the fixed-latency word access, and returns a full 16-bit word on memory_response / memory_response_ready.
- On a write, drives the invalidate address to the non-writing cache for coherence.

---
 rtl/memory_controller.sv | 166 ++++++++++++++++
 tb/tb_memory_controller.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_controller.sv
// Shared backing store for two caches: round-robin grant, fixed-latency word access, byte-merge writes.
// Build option MEMCTRL_INVALIDATE_EN drives a coherence invalidate to the non-writing cache.
module memory_controller #(
    parameter int WORD_ADDR_BITS = 15,
    parameter int MEM_LATENCY    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [24:0] req0,
    input  logic [24:0] req1,
    input  logic        req0_ready,
    input  logic        req1_ready,
    output logic [15:0] resp0,
    output logic [15:0] resp1,
    output logic        resp0_ready,
    output logic        resp1_ready,
    output logic [15:0] invalidate_address_0,
    output logic [15:0] invalidate_address_1,
    output logic        invalidate_valid_0,
    output logic        invalidate_valid_1,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESPOND = 2'd2} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LATENCY - 1);

    state_t      state_q;
    logic [24:0] req_q;
    logic        grant_q;
    logic        last_grant_q;
    logic        busy_q;
    logic [1:0]  rearm_q;
    logic [3:0]  cnt_q;
    logic [15:0] resp0_q;
    logic [15:0] resp1_q;
    logic        resp0_rdy_q;
    logic        resp1_rdy_q;
    logic [15:0] mem_q [2**WORD_ADDR_BITS];

    logic [WORD_ADDR_BITS-1:0] word;
    logic [15:0] rd_word;
    logic [15:0] merged;
    logic [15:0] resp_word;
    logic        elig0;
    logic        elig1;
    logic        pick1;
    logic        mem_we;
    logic        unused_req;

    assign word      = req_q[WORD_ADDR_BITS:1];
    assign rd_word   = mem_q[word];
    assign merged    = req_q[0] ? {req_q[23:16], rd_word[7:0]} : {rd_word[15:8], req_q[23:16]};
    assign resp_word = req_q[24] ? merged : rd_word;
    // A port is only eligible once its ready has been seen low after its last response.
    assign elig0     = req0_ready & rearm_q[0];
    assign elig1     = req1_ready & rearm_q[1];
    assign pick1     = elig1 & (~elig0 | ~last_grant_q);
    assign mem_we    = (state_q == RESPOND) & req_q[24];
    // Upper address bits above the word address alias and are deliberately dropped.
    assign unused_req = ^req_q;

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[word] <= merged;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_q        <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
            rearm_q      <= 2'b11;
            cnt_q        <= 4'd0;
            resp0_q      <= '0;
            resp1_q      <= '0;
            resp0_rdy_q  <= 1'b0;
            resp1_rdy_q  <= 1'b0;
        end else begin
            resp0_q     <= '0;
            resp1_q     <= '0;
            resp0_rdy_q <= 1'b0;
            resp1_rdy_q <= 1'b0;
            if (!req0_ready) rearm_q[0] <= 1'b1;
            if (!req1_ready) rearm_q[1] <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (elig0 | elig1) begin
                        grant_q <= pick1;
                        req_q   <= pick1 ? req1 : req0;
                        cnt_q   <= LAT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == 4'd0) state_q <= RESPOND;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                RESPOND: begin
                    if (grant_q) begin
                        resp1_q     <= resp_word;
                        resp1_rdy_q <= 1'b1;
                        rearm_q[1]  <= 1'b0;
                    end else begin
                        resp0_q     <= resp_word;
                        resp0_rdy_q <= 1'b1;
                        rearm_q[0]  <= 1'b0;
                    end
                    last_grant_q <= grant_q;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp0       = resp0_q;
    assign resp1       = resp1_q;
    assign resp0_ready = resp0_rdy_q;
    assign resp1_ready = resp1_rdy_q;
    assign busy        = busy_q;

`ifdef MEMCTRL_INVALIDATE_EN
    logic [15:0] inv_addr0_q;
    logic [15:0] inv_addr1_q;
    logic        inv_vld0_q;
    logic        inv_vld1_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inv_addr0_q <= '0;
            inv_addr1_q <= '0;
            inv_vld0_q  <= 1'b0;
            inv_vld1_q  <= 1'b0;
        end else begin
            inv_addr0_q <= '0;
            inv_addr1_q <= '0;
            inv_vld0_q  <= 1'b0;
            inv_vld1_q  <= 1'b0;
            if (mem_we) begin
                if (grant_q) begin
                    inv_addr0_q <= {req_q[15:1], 1'b0};
                    inv_vld0_q  <= 1'b1;
                end else begin
                    inv_addr1_q <= {req_q[15:1], 1'b0};
                    inv_vld1_q  <= 1'b1;
                end
            end
        end
    end

    assign invalidate_address_0 = inv_addr0_q;
    assign invalidate_address_1 = inv_addr1_q;
    assign invalidate_valid_0   = inv_vld0_q;
    assign invalidate_valid_1   = inv_vld1_q;
`else
    assign invalidate_address_0 = '0;
    assign invalidate_address_1 = '0;
    assign invalidate_valid_0   = 1'b0;
    assign invalidate_valid_1   = 1'b0;
`endif
endmodule

// File: tb/tb_memory_controller.sv
// Randomized scoreboard bench for memory_controller: a word-array model predicts data, order and timing.
`timescale 1ns/1ps
module tb_memory_controller;
    localparam int WAB = 15;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [24:0] req0 = '0;
    logic [24:0] req1 = '0;
    logic        req0_ready = 1'b0;
    logic        req1_ready = 1'b0;
    logic [15:0] resp0, resp1;
    logic        resp0_ready, resp1_ready;
    logic [15:0] invalidate_address_0, invalidate_address_1;
    logic        invalidate_valid_0, invalidate_valid_1;
    logic        busy;

    memory_controller #(.WORD_ADDR_BITS(WAB), .MEM_LATENCY(LAT)) dut (
        .clock(clk), .reset(rst_n),
        .req0(req0), .req1(req1), .req0_ready(req0_ready), .req1_ready(req1_ready),
        .resp0(resp0), .resp1(resp1), .resp0_ready(resp0_ready), .resp1_ready(resp1_ready),
        .invalidate_address_0(invalidate_address_0), .invalidate_address_1(invalidate_address_1),
        .invalidate_valid_0(invalidate_valid_0), .invalidate_valid_1(invalidate_valid_1),
        .busy(busy)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [15:0] data;
        logic        inv;
        logic [15:0] inv_addr;
    } exp_t;

    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    logic [15:0] mdl[int];
    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int          last_grant_m = 1;
    logic [1:0]  exp_iv;
    logic [15:0] exp_ia[2];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic int word_of(input logic [15:0] addr);
        return int'(addr >> 1) & ((1 << WAB) - 1);
    endfunction

    function automatic logic [15:0] mdl_read(input logic [15:0] addr);
        int w;
        w = word_of(addr);
        return mdl.exists(w) ? mdl[w] : 16'h0000;
    endfunction

    function automatic logic [24:0] rd(input logic [15:0] a);
        return {1'b0, 8'h00, a};
    endfunction

    function automatic logic [24:0] wr(input logic [7:0] b, input logic [15:0] a);
        return {1'b1, b, a};
    endfunction

    function automatic logic [24:0] rand_req();
        logic [15:0] a;
        a = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 31));
        return {1'($urandom_range(0, 1)), 8'($urandom), a};
    endfunction

    task automatic push_exp(input int p, input logic [24:0] r, input int unsigned when);
        exp_t        e;
        logic [15:0] old;
        logic [15:0] nw;
        old = mdl_read(r[15:0]);
        if (r[24]) begin
            if (r[0]) nw = (16'(r[23:16]) << 8) | (old & 16'h00FF);
            else      nw = (old & 16'hFF00) | 16'(r[23:16]);
            mdl[word_of(r[15:0])] = nw;
        end else begin
            nw = old;
        end
        e.cyc  = when;
        e.data = nw;
`ifdef MEMCTRL_INVALIDATE_EN
        e.inv = r[24];
`else
        e.inv = 1'b0;
`endif
        e.inv_addr = r[15:0] & 16'hFFFE;
        if (p == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // ---------------- driver ----------------
    // Issues one or two requests from an idle controller, waits for the responses,
    // keeps ready high for 'hold' extra cycles, then drops it so the port re-arms.
    task automatic run_batch(input logic [1:0] mask, input logic [24:0] r0, input logic [24:0] r1,
                             input int hold);
        int unsigned c;
        int          first;
        int          n;
        @(negedge clk);
        req0 = r0;
        req1 = r1;
        req0_ready = mask[0];
        req1_ready = mask[1];
        c = cyc;
        if (mask == 2'b11) first = (last_grant_m == 1) ? 0 : 1;
        else               first = mask[1] ? 1 : 0;
        push_exp(first, (first == 1) ? r1 : r0, c + LAT + 2);
        if (mask == 2'b11) begin
            push_exp(1 - first, (first == 1) ? r0 : r1, c + 2 * LAT + 4);
            last_grant_m = 1 - first;
        end else begin
            last_grant_m = first;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_grant cycle %0d: got %0b want 1", cyc, busy);
        end
        n = 0;
        while ((exp_q0.size() + exp_q1.size()) != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            errors++;
            $display("FAIL batch_timeout cycle %0d: got %0d pending want 0", cyc,
                     exp_q0.size() + exp_q1.size());
        end
        repeat (hold) @(negedge clk);
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic check_port(input int p, input logic rv, input logic [15:0] rdat);
        exp_t e;
        logic due;
        due = 1'b0;
        e   = '0;
        if (p == 0) begin
            if (exp_q0.size() > 0 && exp_q0[0].cyc == cyc) begin
                due = 1'b1;
                e   = exp_q0.pop_front();
            end
        end else begin
            if (exp_q1.size() > 0 && exp_q1[0].cyc == cyc) begin
                due = 1'b1;
                e   = exp_q1.pop_front();
            end
        end
        checks++;
        if (due) begin
            if (rv !== 1'b1 || rdat !== e.data) begin
                errors++;
                $display("FAIL resp%0d cycle %0d: got ready=%0b data=%h want ready=1 data=%h",
                         p, cyc, rv, rdat, e.data);
            end
            if (e.inv) begin
                exp_iv[1-p] = 1'b1;
                exp_ia[1-p] = e.inv_addr;
            end
        end else if (rv !== 1'b0 || rdat !== 16'h0000) begin
            errors++;
            $display("FAIL resp%0d_idle cycle %0d: got ready=%0b data=%h want ready=0 data=0000",
                     p, cyc, rv, rdat);
        end
    endtask

    always @(negedge clk) begin
        exp_iv    = 2'b00;
        exp_ia[0] = '0;
        exp_ia[1] = '0;
        check_port(0, resp0_ready, resp0);
        check_port(1, resp1_ready, resp1);
        checks++;
        if (invalidate_valid_0 !== exp_iv[0] || (exp_iv[0] && invalidate_address_0 !== exp_ia[0])) begin
            errors++;
            $display("FAIL inv0 cycle %0d: got v=%0b a=%h want v=%0b a=%h",
                     cyc, invalidate_valid_0, invalidate_address_0, exp_iv[0], exp_ia[0]);
        end
        checks++;
        if (invalidate_valid_1 !== exp_iv[1] || (exp_iv[1] && invalidate_address_1 !== exp_ia[1])) begin
            errors++;
            $display("FAIL inv1 cycle %0d: got v=%0b a=%h want v=%0b a=%h",
                     cyc, invalidate_valid_1, invalidate_address_1, exp_iv[1], exp_ia[1]);
        end
        if (resp0_ready === 1'b1 || resp1_ready === 1'b1) begin
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_at_resp cycle %0d: got %0b want 0", cyc, busy);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({resp0, resp1, resp0_ready, resp1_ready, invalidate_address_0, invalidate_address_1,
             invalidate_valid_0, invalidate_valid_1, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%0b r0=%h r1=%h rv=%0b%0b want all 0",
                     busy, resp0, resp1, resp0_ready, resp1_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);

        run_batch(2'b11, rd(16'h0010), rd(16'h0012), 0);
        run_batch(2'b11, rd(16'h0014), rd(16'h0016), 1);
        run_batch(2'b01, rd(16'h0010), '0, 0);
        run_batch(2'b01, wr(8'hAB, 16'h0021), '0, 0);
        run_batch(2'b01, rd(16'h0020), '0, 0);
        run_batch(2'b10, '0, rd(16'h0020), 3);
        run_batch(2'b10, '0, wr(8'h77, 16'h0100), 3);
        run_batch(2'b11, wr(8'hC3, 16'h0030), rd(16'h0030), 2);
        run_batch(2'b01, wr(8'h33, 16'h0005), '0, 0);

        // Abort a write mid-access: nothing may commit or respond.
        @(negedge clk);
        req0 = wr(8'h5A, 16'h0004);
        req0_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_access: got %0b want 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || resp0_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: got busy=%0b rv0=%0b want busy=0 rv0=0", busy, resp0_ready);
        end
        req0_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        last_grant_m = 1;
        repeat (LAT + 3) @(negedge clk);
        run_batch(2'b01, rd(16'h0004), '0, 0);
        run_batch(2'b11, rd(16'h0004), rd(16'h0005), 0);

        for (int i = 0; i < 60; i++) begin
            run_batch(2'($urandom_range(1, 3)), rand_req(), rand_req(), $urandom_range(0, 3));
        end

        repeat (2 * LAT + 6) @(negedge clk);
        #1;
        checks++;
        if ((exp_q0.size() + exp_q1.size()) != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d entries want 0", exp_q0.size() + exp_q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
